// File: rtl/shift_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_sequencer_pkg
//   Shared constants for the shift sequencer and the 4-bit universal shift
//   register it drives.
//   - SEL_* : select encoding understood by the shift register
//   - state_t : sequencer FSM states, also exposed on the debug output
//   - shift_sel() : maps a shift direction bit to its select code
// ---------------------------------------------------------------------------
package shift_sequencer_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // dir = 0 shifts right, dir = 1 shifts left.
    function automatic logic [1:0] shift_sel(input logic dir);
        return dir ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//   Request channel into the shift sequencer.
//   Handshake: a request transfers on a rising clk edge where
//   req_valid && req_ready. req_data/req_dir/req_count are sampled only at
//   that edge; the requester may change them at any other time. req_ready is
//   high only while the sequencer is idle.
//   Signals:
//     req_valid  requester -> sequencer  request present
//     req_ready  sequencer -> requester  sequencer can accept
//     req_data   requester -> sequencer  value to parallel-load (WIDTH)
//     req_dir    requester -> sequencer  0 = shift right, 1 = shift left
//     req_count  requester -> sequencer  number of shift cycles (CNT_W)
//   Modports: master = requester, slave = sequencer.
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic             req_dir;
    logic [CNT_W-1:0] req_count;

    modport master (
        output req_valid,
        output req_data,
        output req_dir,
        output req_count,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_dir,
        input  req_count,
        output req_ready
    );
endinterface

// File: rtl/shift_seq_checker.sv
// ---------------------------------------------------------------------------
// shift_seq_checker
//   Self-check for the shift sequencer. At request acceptance it computes
//   the value the shift register should hold after the requested shifts
//   (zero fill, truncated to WIDTH). When the sequencer is in CAPTURE it
//   compares the register's q against that value and sets a sticky err.
//   Only instantiated when SHIFT_SEQ_CHECK_EN is defined.
//   Ports:
//     clk, reset  rising-edge clock, synchronous active-high reset
//     accept      request handshake this cycle
//     data/dir/count  request fields, valid when accept is high
//     capture     sequencer is in CAPTURE this cycle
//     q_in        shift register output
//     err         sticky mismatch flag, cleared only by reset
// ---------------------------------------------------------------------------
module shift_seq_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic [CNT_W-1:0] count,
    input  logic             capture,
    input  logic [WIDTH-1:0] q_in,
    output logic             err
);

    logic [WIDTH-1:0] expected;

    always_ff @(posedge clk) begin
        if (reset) begin
            expected <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                // Counts at or beyond WIDTH naturally yield zero.
                expected <= dir ? (data << count) : (data >> count);
            end
            if (capture && (q_in != expected)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Drives a universal shift register through one request: parallel load,
//   req_count shift cycles in the requested direction, then one hold cycle
//   in which q is captured into result and done pulses.
//   Optional self-check: define SHIFT_SEQ_CHECK_EN to instantiate
//   shift_seq_checker; otherwise err is tied low.
//   Ports:
//     clk, reset  rising-edge clock, synchronous active-high reset
//     req         request channel (shift_sequencer_if.slave)
//     q_in        q output of the shift register
//     b           parallel data to the shift register (registered)
//     select      mode to the shift register (registered)
//     busy        high in every state except IDLE
//     result      captured q, held until the next capture or reset
//     done        one-cycle pulse, result valid in the same cycle
//     err         sticky self-check flag
//     dbg_state   current FSM state
//   Latency (handshake edge ends cycle 0): LOAD in cycle 1, SHIFT in cycles
//   2..count+1, CAPTURE in cycle count+2, done in cycle count+3.
// ---------------------------------------------------------------------------
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    shift_sequencer_if.slave req,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] b,
    output logic [1:0]       select,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output state_t           dbg_state
);

    state_t           state;
    logic             dir_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] remaining;
    logic             accept;

    assign req.req_ready = (state == IDLE);
    assign accept        = req.req_valid && (state == IDLE);
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

    // select/b are set on the edge that enters each state, so the shift
    // register sees a clean value for the whole cycle the state lasts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            select    <= SEL_HOLD;
            b         <= '0;
            result    <= '0;
            done      <= 1'b0;
            dir_r     <= 1'b0;
            count_r   <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    select <= SEL_HOLD;
                    if (accept) begin
                        b       <= req.req_data;
                        dir_r   <= req.req_dir;
                        count_r <= req.req_count;
                        select  <= SEL_LOAD;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (count_r != '0) begin
                        select    <= shift_sel(dir_r);
                        remaining <= count_r;
                        state     <= SHIFT;
                    end else begin
                        select <= SEL_HOLD;
                        state  <= CAPTURE;
                    end
                end
                SHIFT: begin
                    // Leave on the last shift cycle; remaining never goes
                    // below 1, so the maximum count cannot wrap.
                    if (remaining == CNT_W'(1)) begin
                        select <= SEL_HOLD;
                        state  <= CAPTURE;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    result <= q_in;
                    done   <= 1'b1;
                    select <= SEL_HOLD;
                    state  <= IDLE;
                end
                default: begin
                    select <= SEL_HOLD;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_CHECK_EN
    shift_seq_checker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .data    (req.req_data),
        .dir     (req.req_dir),
        .count   (req.req_count),
        .capture (state == CAPTURE),
        .q_in    (q_in),
        .err     (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//   Directed bench for shift_sequencer. A behavioural 4-bit universal shift
//   register closes the loop from select/b back to q_in. Expected results
//   are queued when a request is driven and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

`ifdef SHIFT_SEQ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) rif ();

    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] b;
    logic [1:0]       select;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             err;
    state_t           dbg_state;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (rif),
        .q_in      (q_in),
        .b         (b),
        .select    (select),
        .busy      (busy),
        .result    (result),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- shift register model ----------------
    logic [WIDTH-1:0] sr_q;
    logic             q_force = 1'b0;

    assign q_in = q_force ? '0 : sr_q;

    always @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            case (select)
                2'b11:   sr_q <= b;
                2'b01:   sr_q <= sr_q >> 1;
                2'b10:   sr_q <= sr_q << 1;
                default: sr_q <= sr_q;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            check("sb_pending", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                check("sb_result", 32'(result), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a request at a negedge; returns just after the handshake edge.
    task automatic drive_req(input logic [WIDTH-1:0] d, input logic dir, input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        check("ready_idle", 32'(rif.req_ready), 32'(1));
        rif.req_valid = 1'b1;
        rif.req_data  = d;
        rif.req_dir   = dir;
        rif.req_count = cnt;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        rif.req_data  = '0;
    endtask

    // Full operation with per-cycle checks of select/busy/done.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic dir, input logic [CNT_W-1:0] cnt,
                          input logic [WIDTH-1:0] exp_res);
        int n;
        logic [1:0] exp_sel;
        n = int'(cnt);
        exp_q.push_back(exp_res);
        drive_req(d, dir, cnt);
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (c == 1)          exp_sel = 2'b11;
            else if (c <= n + 1) exp_sel = dir ? 2'b10 : 2'b01;
            else                 exp_sel = 2'b00;
            check($sformatf("select_c%0d", c), 32'(select), 32'(exp_sel));
            check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= n + 2));
            check($sformatf("done_c%0d", c), 32'(done), 32'(c == n + 3));
            if (c == 1) check("b_load", 32'(b), 32'(d));
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check(tag, 32'(done), 32'(1));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rif.req_valid = 1'b0;
        rif.req_data  = '0;
        rif.req_dir   = 1'b0;
        rif.req_count = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state",  32'(dbg_state), 32'(IDLE));
        check("rst_select", 32'(select), 32'(0));
        check("rst_b",      32'(b), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_done",   32'(done), 32'(0));
        check("rst_busy",   32'(busy), 32'(0));
        check("rst_err",    32'(err), 32'(0));
        check("rst_ready",  32'(rif.req_ready), 32'(1));
        reset = 1'b0;

        // Reset mid-SHIFT: count 5, reset high in cycle 3
        drive_req(4'b0110, 1'b1, 3'd5);
        @(negedge clk);
        check("mid_c1_select", 32'(select), 32'(2'b11));
        @(negedge clk);
        check("mid_c2_select", 32'(select), 32'(2'b10));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_state",  32'(dbg_state), 32'(IDLE));
        check("mid_select", 32'(select), 32'(0));
        check("mid_busy",   32'(busy), 32'(0));
        check("mid_done",   32'(done), 32'(0));
        check("mid_result", 32'(result), 32'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_no_done", 32'(done), 32'(0));
        end

        // Right shift by 1, left shift by 2, zero count
        run_op(4'b1011, 1'b0, 3'd1, 4'b0101);
        run_op(4'b1011, 1'b1, 3'd2, 4'b1100);
        run_op(4'b1011, 1'b0, 3'd0, 4'b1011);
        check("hold_result", 32'(result), 32'(4'b1011));

        // Busy and back-to-back: req_valid held high across a count-3 op
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_data  = 4'b1011;
        rif.req_dir   = 1'b0;
        rif.req_count = 3'd3;
        exp_q.push_back(4'b0001);
        @(posedge clk);
        #1;
        rif.req_data  = 4'b0110;
        rif.req_dir   = 1'b1;
        rif.req_count = 3'd1;
        exp_q.push_back(4'b1100);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), 32'(rif.req_ready), 32'(0));
            check($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'(1));
        end
        @(negedge clk);
        check("b2b_done_c6",  32'(done), 32'(1));
        check("b2b_ready_c6", 32'(rif.req_ready), 32'(1));
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_select", 32'(select), 32'(2'b11));
        check("b2b_second_b",      32'(b), 32'(4'b0110));
        wait_done("b2b_second_done");

        // Larger counts, including the maximum
        run_op(4'b1000, 1'b0, 3'd3, 4'b0001);
        run_op(4'b1111, 1'b1, 3'd7, 4'b0000);
        check("err_clean", 32'(err), 32'(0));

        // Self-check: q_in forced to zero during CAPTURE of 1011 >> 1
        exp_q.push_back(4'b0000);
        drive_req(4'b1011, 1'b0, 3'd1);
        @(negedge clk);
        check("chk_c1_select", 32'(select), 32'(2'b11));
        @(negedge clk);
        check("chk_c2_select", 32'(select), 32'(2'b01));
        @(posedge clk);
        #1;
        q_force = 1'b1;
        @(negedge clk);
        check("chk_c3_state", 32'(dbg_state), 32'(CAPTURE));
        @(posedge clk);
        #1;
        q_force = 1'b0;
        @(negedge clk);
        check("chk_done", 32'(done), 32'(1));
        check("chk_err",  32'(err), 32'(EXP_ERR));
        run_op(4'b0011, 1'b1, 3'd1, 4'b0110);
        check("chk_err_sticky", 32'(err), 32'(EXP_ERR));
        pulse_reset();
        @(negedge clk);
        check("chk_err_reset", 32'(err), 32'(0));

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command sequencer that sits directly upstream of the 4-bit universal shift register and drives its `b` and `select` inputs.
- Accepts a request through a valid/ready handshake, then drives the register in order: parallel load, N shift cycles in the requested direction, one hold cycle.
- Captures the register's `q` as the result and pulses `done`.
- Removes the hand-written select sequencing from benches and higher-level controllers.

Parameters:
- WIDTH, 4: data width; matches the shift register.
- CNT_W, 3: width of the shift-count field; up to 2^CNT_W-1 shifts per request.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; transfer occurs when req_valid && req_ready at a clk edge
- req_data  input  WIDTH  value to parallel-load
- req_dir  input  1  0 = shift right, 1 = shift left
- req_count  input  CNT_W  number of shift cycles
- q_in  input  WIDTH  `q` output of the shift register
- b  output  WIDTH  parallel data to the shift register
- select  output  2  mode to the shift register
- busy  output  1  high in any state except IDLE
- result  output  WIDTH  captured `q` value
- done  output  1  one-cycle pulse; `result` is valid in the same cycle
- err  output  1  sticky self-check flag; see Optional Feature

Behaviour:
- Select encoding (fixed): 2'b00 hold, 2'b01 shift right, 2'b10 shift left, 2'b11 parallel load. Shifts zero-fill.
- Reset (synchronous; overrides everything, including mid-operation):
  - state = IDLE; select = 00; b = 0; result = 0; done = 0; busy = 0; err = 0.
  - Any in-flight request is dropped with no done pulse.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE.
  - IDLE: req_ready = 1, select = 00. On handshake, latch data, dir and count into internal registers; next state LOAD.
  - LOAD (1 cycle): select = 11, b = latched data. Next state SHIFT if count != 0, else CAPTURE.
  - SHIFT: select = 01 if dir = 0, 10 if dir = 1. A remaining-count register decrements each cycle; after exactly count SHIFT cycles, go to CAPTURE.
  - CAPTURE (1 cycle): select = 00. At the closing edge, result <= q_in and done <= 1; next state IDLE.
- Outputs from registers: select, b, done and result are registered, so the shift register sees a clean value for a full cycle.
- b holds the latched data in all non-IDLE states and holds its last value in IDLE.
- Latency (handshake edge = end of cycle 0):
  - LOAD in cycle 1, SHIFT in cycles 2..count+1, CAPTURE in cycle count+2.
  - done high in cycle count+3.
  - count = 0 gives done in cycle 3.
- Back-to-back requests: done is asserted in IDLE, so a new request may be accepted in the same cycle done is high.
- While busy, req_valid is ignored and inputs are not sampled. Inputs only need to be stable at the handshake edge.
- Maximum count 2^CNT_W-1: the remaining-count register must not wrap, and the comparison is against 1 before leaving SHIFT.
- result holds its value until the next CAPTURE or reset.

Optional Feature:
- Macro: SHIFT_SEQ_CHECK_EN.
- Defined:
  - At the handshake, compute expected = req_data >> req_count (dir 0) or << req_count (dir 1), truncated to WIDTH, zero fill.
  - At CAPTURE, if q_in != expected, set err = 1. err stays set until reset.
- Undefined: err is tied to 0 and no checker logic is synthesised.

Decomposition:
- Shared constants header/package:
  - SEL_HOLD = 2'b00, SEL_SHR = 2'b01, SEL_SHL = 2'b10, SEL_LOAD = 2'b11.
  - State encodings IDLE/LOAD/SHIFT/CAPTURE.
- The shift register's own model uses the same select constants.
- No sub-module is required. The optional checker is a natural small sub-module, shift_seq_checker, instantiated only under SHIFT_SEQ_CHECK_EN.

Test Plan:
- Right shift: req_data = 1011, dir = 0, count = 1 -> select 11,01,00 in cycles 1-3; done in cycle 4; result = 0101.
- Left shift: req_data = 1011, dir = 1, count = 2 -> two cycles of select = 10; done in cycle 5; result = 1100.
- Zero count: req_data = 1011, count = 0 -> LOAD then CAPTURE with no shift cycle; done in cycle 3; result = 1011.
- Busy and back-to-back:
  - Hold req_valid high through a count = 3 operation -> req_ready = 0 for cycles 1-5; second request ignored while busy.
  - Second request is accepted in the cycle done = 1.
- Reset mid-SHIFT: reset = 1 in cycle 3 of a count = 5 request -> next cycle state IDLE, select = 00, busy = 0, no done pulse, result unchanged at 0.
- With SHIFT_SEQ_CHECK_EN defined: force q_in = 0000 during CAPTURE of a 1011 >> 1 request -> err = 1 and stays 1 until reset. With the macro undefined, the same stimulus leaves err = 0.
